imm_gen_pipe: RTL and testbench

Registered, XLEN-parametrised RISC-V immediate generator with a valid/ready handshake and a 2-entry skid buffer. It sits between fetch and the register-read/execute stage of the pipelined core. It decodes the immediate format from the opcode itself, covering I/S/B/U/J; R-type yields zero. It can also flag unsupported opcodes.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_decode.sv | 60 ++++++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format codes, RV opcodes and
// the skid-buffer state encoding.
package imm_pkg;

  // Format codes reported on out_fmt
  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_R   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Skid buffer occupancy
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: instruction -> (fmt, sign-extended imm, illegal).
// Illegal-opcode detection only exists when IMM_ILLEGAL_EN is defined; otherwise
// unknown opcodes decode as R-type with a zero immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // Opcode -> format, then assemble the 32-bit immediate and widen to XLEN
  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    imm32   = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
`ifdef IMM_ILLEGAL_EN
        fmt     = FMT_ILL;
        illegal = 1'b1;
`else
        fmt     = FMT_R;
`endif
      end
    endcase
    // Sign bit of every nonzero format is instr[31], which lands in imm32[31]
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and 2-entry skid
// buffer. in_ready depends only on the registered state, so there is no
// combinational out_ready -> in_ready path.
// Optional feature macro: IMM_ILLEGAL_EN (report unknown opcodes as illegal).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PASS_INSTR = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_instr,
  output logic            out_illegal
);

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [31:0]     fwd_instr;
  logic            accept;

  buf_state_e      state_q;
  logic            in_ready_q, out_valid_q;
  logic [XLEN-1:0] out_imm_q, skid_imm_q;
  logic [2:0]      out_fmt_q, skid_fmt_q;
  logic [31:0]     out_instr_q, skid_instr_q;
  logic            out_ill_q, skid_ill_q;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Instruction forwarding is dropped at the input so the registers fold away
  assign fwd_instr = (PASS_INSTR != 0) ? in_instr : 32'h0;
  assign accept    = in_valid && in_ready_q;

  // Buffer FSM with registered handshake outputs and payload registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StEmpty;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_instr_q  <= '0;
      out_ill_q    <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_instr_q <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            out_imm_q   <= dec_imm;
            out_fmt_q   <= dec_fmt;
            out_instr_q <= fwd_instr;
            out_ill_q   <= dec_illegal;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && out_ready) begin
            out_imm_q   <= dec_imm;
            out_fmt_q   <= dec_fmt;
            out_instr_q <= fwd_instr;
            out_ill_q   <= dec_illegal;
          end else if (accept) begin
            skid_imm_q   <= dec_imm;
            skid_fmt_q   <= dec_fmt;
            skid_instr_q <= fwd_instr;
            skid_ill_q   <= dec_illegal;
            in_ready_q   <= 1'b0;
            state_q      <= StFull;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can happen
          if (out_ready) begin
            out_imm_q   <= skid_imm_q;
            out_fmt_q   <= skid_fmt_q;
            out_instr_q <= skid_instr_q;
            out_ill_q   <= skid_ill_q;
            in_ready_q  <= 1'b1;
            state_q     <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_instr   = out_instr_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share the
// same stimulus; expected values are hand-computed constants.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, ins32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] ins64;
  logic [2:0]  fmt64;

  int passed = 0;
  int total  = 0;

`ifdef IMM_ILLEGAL_EN
  localparam logic [2:0] ExpIllFmt = 3'd7;
  localparam logic       ExpIllBit = 1'b1;
`else
  localparam logic [2:0] ExpIllFmt = 3'd5;
  localparam logic       ExpIllBit = 1'b0;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .XLEN(32),
    .PASS_INSTR(1)
  ) dut32 (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (rdy32),
    .in_instr    (in_instr),
    .out_valid   (vld32),
    .out_ready   (out_ready),
    .out_imm     (imm32),
    .out_fmt     (fmt32),
    .out_instr   (ins32),
    .out_illegal (ill32)
  );

  imm_gen_pipe #(
    .XLEN(64),
    .PASS_INSTR(1)
  ) dut64 (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (rdy64),
    .in_instr    (in_instr),
    .out_valid   (vld64),
    .out_ready   (out_ready),
    .out_imm     (imm64),
    .out_fmt     (fmt64),
    .out_instr   (ins64),
    .out_illegal (ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output check of both instances
  task automatic chk_beat(input string tag, input logic [31:0] ins,
                          input logic [63:0] e64, input logic [2:0] f, input logic il);
    chk({tag, " vld"}, {63'd0, vld32}, 64'd1);
    chk({tag, " imm32"}, {32'd0, imm32}, {32'd0, e64[31:0]});
    chk({tag, " fmt32"}, {61'd0, fmt32}, {61'd0, f});
    chk({tag, " ins32"}, {32'd0, ins32}, {32'd0, ins});
    chk({tag, " ill32"}, {63'd0, ill32}, {63'd0, il});
    chk({tag, " imm64"}, imm64, e64);
    chk({tag, " fmt64"}, {61'd0, fmt64}, {61'd0, f});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " vld32"}, {63'd0, vld32}, 64'd0);
    chk({tag, " vld64"}, {63'd0, vld64}, 64'd0);
    chk({tag, " rdy32"}, {63'd0, rdy32}, 64'd1);
    chk({tag, " rdy64"}, {63'd0, rdy64}, 64'd1);
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    resetn = 1'b1;

    // Reset state
    chk_idle("reset");
    chk("reset imm32", {32'd0, imm32}, 64'd0);
    chk("reset imm64", imm64, 64'd0);
    chk("reset fmt", {61'd0, fmt32}, 64'd0);
    chk("reset instr", {32'd0, ins32}, 64'd0);
    chk("reset ill", {62'd0, ill32, ill64}, 64'd0);

    // Back-to-back stream with out_ready=1, one beat per cycle
    in_valid = 1'b1;
    in_instr = 32'hFFF0_0093;
    step();
    chk_beat("I", 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
    in_instr = 32'h0011_2623;
    step();
    chk_beat("S", 32'h0011_2623, 64'h0000_0000_0000_000C, 3'd1, 1'b0);
    in_instr = 32'hFE00_0EE3;
    step();
    chk_beat("B", 32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    in_instr = 32'h0080_00EF;
    step();
    chk_beat("J", 32'h0080_00EF, 64'h0000_0000_0000_0008, 3'd4, 1'b0);
    in_instr = 32'h8000_0537;
    step();
    chk_beat("U neg", 32'h8000_0537, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0);
    in_instr = 32'h1234_50B7;
    step();
    chk_beat("U pos", 32'h1234_50B7, 64'h0000_0000_1234_5000, 3'd3, 1'b0);
    in_instr = 32'h00B5_0533;
    step();
    chk_beat("R", 32'h00B5_0533, 64'd0, 3'd5, 1'b0);
    in_instr = 32'h0000_007F;
    step();
    chk_beat("ILL", 32'h0000_007F, 64'd0, ExpIllFmt, ExpIllBit);
    chk("ILL ill64", {63'd0, ill64}, {63'd0, ExpIllBit});

    // Drain to empty
    in_valid = 1'b0;
    step();
    chk_idle("drain");

    // Backpressure: three offered, two taken, then in_ready drops
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0093;
    step();
    chk("bp1 rdy", {63'd0, rdy32}, 64'd1);
    chk_beat("bp1", 32'h0050_0093, 64'd5, 3'd0, 1'b0);
    in_instr = 32'h00A0_0113;
    step();
    chk("bp2 rdy32", {63'd0, rdy32}, 64'd0);
    chk("bp2 rdy64", {63'd0, rdy64}, 64'd0);
    chk_beat("bp2 hold", 32'h0050_0093, 64'd5, 3'd0, 1'b0);
    in_instr = 32'h00F0_0193;
    step();
    chk("bp3 rdy", {63'd0, rdy32}, 64'd0);
    chk_beat("bp3 hold", 32'h0050_0093, 64'd5, 3'd0, 1'b0);
    // Release: FULL drains only, the pending beat waits one cycle
    out_ready = 1'b1;
    step();
    chk("rel1 rdy", {63'd0, rdy32}, 64'd1);
    chk_beat("rel1", 32'h00A0_0113, 64'd10, 3'd0, 1'b0);
    step();
    chk_beat("rel2", 32'h00F0_0193, 64'd15, 3'd0, 1'b0);
    in_valid = 1'b0;
    step();
    chk_idle("rel3");

    // Reset while FULL discards both beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0070_0093;
    step();
    in_instr = 32'h0080_0093;
    step();
    chk("full rdy", {63'd0, rdy32}, 64'd0);
    resetn   = 1'b0;
    in_valid = 1'b0;
    step();
    resetn = 1'b1;
    chk_idle("rst full");
    chk("rst imm32", {32'd0, imm32}, 64'd0);
    chk("rst imm64", imm64, 64'd0);
    chk("rst instr", {32'd0, ins32}, 64'd0);
    out_ready = 1'b1;
    step();
    chk_idle("post rst1");
    step();
    chk_idle("post rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
